// File: rtl/usb_rx_packetizer_pkg.sv
// usb_pkg: shared definitions for the USB receive packetizer.
//   - PID[1:0] packet-type codes
//   - CRC5 / CRC16 polynomials, init values and good-packet residuals
//   - packetizer state encoding
//   - pid_check(): PID byte integrity test (low nibble == ~high nibble)
package usb_pkg;

    localparam logic [1:0] PID_TOKEN     = 2'b01;
    localparam logic [1:0] PID_DATA      = 2'b11;
    localparam logic [1:0] PID_HANDSHAKE = 2'b10;
    localparam logic [1:0] PID_SPECIAL   = 2'b00;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {
        HUNT,
        PID,
        DATA,
        DONE,
        DROP
    } rx_state_t;

    function automatic logic pid_check(input logic [7:0] pid_byte);
        return pid_byte[3:0] == ~pid_byte[7:4];
    endfunction

endpackage

// File: rtl/usb_rx_packetizer_crc_serial.sv
// usb_crc_serial: bit-serial CRC in USB transmission order (one bit per en).
// Parameters: WIDTH, POLY, INIT.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (register -> 0)
//   clr       - synchronous load of INIT (takes priority over en)
//   en, din   - shift one bit into the CRC
//   crc_next  - value the register takes at the next clock edge, so a
//               residual check can include a bit arriving this cycle
module usb_crc_serial #(
    parameter int unsigned       WIDTH = 5,
    parameter logic [WIDTH-1:0]  POLY  = '0,
    parameter logic [WIDTH-1:0]  INIT  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc_next
);

    logic [WIDTH-1:0] crc_q;
    logic [WIDTH-1:0] crc_upd;
    logic             fb;

    always_comb begin
        fb      = din ^ crc_q[WIDTH-1];
        crc_upd = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        crc_next = crc_q;
        if (clr) begin
            crc_next = INIT;
        end else if (en) begin
            crc_next = crc_upd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_next;
        end
    end

endmodule

// File: rtl/usb_rx_packetizer.sv
// usb_rx_packetizer: turns the destuffed receive bit stream into PID, data
// bytes and per-packet status for the protocol engine.
// Optional feature macro: USB_RX_CRC_EN (CRC5/CRC16 checking; when undefined
// no CRC logic exists and rx_err[0] reports only PID errors).
// Ports:
//   c_48, rst     - 48 MHz clock, asynchronous active-high reset
//   d, dv         - decoded bit and its strobe
//   eop           - SE0 level from the line
//   rx_pid        - PID[3:0] of the current packet
//   rx_pid_valid  - pulse when the PID byte is accepted
//   rx_data       - byte following the PID (LSB-first assembly)
//   rx_valid      - pulse per rx_data byte (CRC bytes included)
//   rx_len        - byte count after PID, held from rx_done to next packet
//   rx_done       - end-of-packet pulse
//   rx_ok         - rx_done qualifier, no errors
//   rx_err        - {overflow, align_err, crc_or_pid_err}
module usb_rx_packetizer
    import usb_pkg::*;
#(
    parameter int unsigned MAX_BYTES      = 66,
    parameter int unsigned SYNC_MIN_ZEROS = 3
) (
    input  logic       c_48,
    input  logic       rst,
    input  logic       d,
    input  logic       dv,
    input  logic       eop,
    output logic [3:0] rx_pid,
    output logic       rx_pid_valid,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [6:0] rx_len,
    output logic       rx_done,
    output logic       rx_ok,
    output logic [2:0] rx_err
);

    localparam logic [6:0] MAX_LEN = 7'(MAX_BYTES);

    rx_state_t  state, state_next;
    logic       eop_q;
    logic       eop_rise;
    logic [2:0] zcnt;
    logic       zcnt_ge;
    logic [7:0] sr;
    logic [7:0] sr_next;
    logic [2:0] bitcnt;
    logic [2:0] bitcnt_next;
    logic [6:0] len_next;
    logic       at_max;
    logic       hs_len_bad;
    logic       pid_entry;
    logic       shift_en;
    logic       pid_byte;
    logic       pid_good;
    logic       byte_done;
    logic       done_entry;
    logic       data_end;
    logic       crc_bad;
    logic [2:0] err_set;

    assign eop_rise = eop & ~eop_q;
    assign zcnt_ge  = {29'd0, zcnt} >= SYNC_MIN_ZEROS;
    assign sr_next  = {d, sr[7:1]};
    assign pid_good = pid_check(sr_next);

    always_comb begin
        state_next = state;
        pid_entry  = 1'b0;
        shift_en   = 1'b0;
        pid_byte   = 1'b0;
        byte_done  = 1'b0;
        case (state)
            HUNT: begin
                if (dv && d && zcnt_ge) begin
                    pid_entry  = 1'b1;
                    state_next = PID;
                end
            end
            PID: begin
                shift_en = dv;
                pid_byte = dv && (bitcnt == 3'd7);
                if (pid_byte) begin
                    state_next = pid_good ? DATA : DROP;
                end
                if (eop_rise) begin
                    state_next = DONE;
                end
            end
            DATA: begin
                shift_en  = dv;
                byte_done = dv && (bitcnt == 3'd7);
                if (eop_rise) begin
                    state_next = DONE;
                end
            end
            DROP: begin
                if (eop_rise) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = HUNT;
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // End-of-packet checks use the post-bit values so a bit that shares its
    // cycle with eop_rise is counted before the packet is judged.
    assign bitcnt_next = bitcnt + 3'(shift_en);
    assign at_max      = (rx_len == MAX_LEN);
    assign len_next    = rx_len + 7'(byte_done && !at_max);
    assign hs_len_bad  = (rx_pid[1:0] == PID_HANDSHAKE) && (len_next != 7'd0);
    assign done_entry  = (state_next == DONE);
    assign data_end    = (state == DATA) && eop_rise;

`ifdef USB_RX_CRC_EN
    logic [4:0]  crc5_next;
    logic [15:0] crc16_next;
    logic        crc5_en;
    logic        crc16_en;

    assign crc5_en  = shift_en && (state == DATA) && (rx_pid[1:0] == PID_TOKEN);
    assign crc16_en = shift_en && (state == DATA) && (rx_pid[1:0] == PID_DATA);

    usb_crc_serial #(
        .WIDTH (5),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk      (c_48),
        .rst      (rst),
        .clr      (pid_entry),
        .en       (crc5_en),
        .din      (d),
        .crc_next (crc5_next)
    );

    usb_crc_serial #(
        .WIDTH (16),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk      (c_48),
        .rst      (rst),
        .clr      (pid_entry),
        .en       (crc16_en),
        .din      (d),
        .crc_next (crc16_next)
    );

    always_comb begin
        crc_bad = 1'b0;
        if (rx_pid[1:0] == PID_TOKEN) begin
            crc_bad = (crc5_next != CRC5_RESIDUAL);
        end else if (rx_pid[1:0] == PID_DATA) begin
            crc_bad = (crc16_next != CRC16_RESIDUAL);
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    assign err_set[2] = byte_done && at_max;
    assign err_set[1] = ((state == PID) && eop_rise) ||
                        (data_end && ((bitcnt_next != 3'd0) || hs_len_bad));
    assign err_set[0] = (pid_byte && !pid_good) || (data_end && crc_bad);

    always_ff @(posedge c_48 or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            eop_q        <= 1'b0;
            zcnt         <= '0;
            sr           <= '0;
            bitcnt       <= '0;
            rx_pid       <= '0;
            rx_pid_valid <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_len       <= '0;
            rx_done      <= 1'b0;
            rx_ok        <= 1'b0;
            rx_err       <= '0;
        end else begin
            state <= state_next;
            eop_q <= eop;

            if (state != HUNT) begin
                zcnt <= '0;
            end else if (dv) begin
                if (d) begin
                    zcnt <= '0;
                end else if (zcnt != 3'd7) begin
                    zcnt <= zcnt + 3'd1;
                end
            end

            if (shift_en) begin
                sr <= sr_next;
            end

            if (pid_entry) begin
                bitcnt <= '0;
                rx_len <= '0;
                rx_err <= '0;
            end else begin
                bitcnt <= bitcnt_next;
                rx_len <= len_next;
                rx_err <= rx_err | err_set;
            end

            rx_pid_valid <= pid_byte && pid_good;
            if (pid_byte && pid_good) begin
                rx_pid <= sr_next[3:0];
            end

            rx_valid <= byte_done && !at_max;
            if (byte_done && !at_max) begin
                rx_data <= sr_next;
            end

            rx_done <= done_entry;
            rx_ok   <= done_entry && !(|(rx_err | err_set));
        end
    end

endmodule

// File: tb/tb_usb_rx_packetizer.sv
// Directed bench for usb_rx_packetizer: drives bits one per 4 clocks,
// logs output pulses on the falling edge and compares against hand-computed
// expectations.
module tb_usb_rx_packetizer;

    typedef logic [7:0] byte_q_t[$];

`ifdef USB_RX_CRC_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic       c_48 = 1'b0;
    logic       rst  = 1'b1;
    logic       d    = 1'b0;
    logic       dv   = 1'b0;
    logic       eop  = 1'b0;
    logic [3:0] rx_pid;
    logic       rx_pid_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [6:0] rx_len;
    logic       rx_done;
    logic       rx_ok;
    logic [2:0] rx_err;

    always #5 c_48 = ~c_48;

    usb_rx_packetizer #(
        .MAX_BYTES      (66),
        .SYNC_MIN_ZEROS (3)
    ) dut (
        .c_48         (c_48),
        .rst          (rst),
        .d            (d),
        .dv           (dv),
        .eop          (eop),
        .rx_pid       (rx_pid),
        .rx_pid_valid (rx_pid_valid),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_len       (rx_len),
        .rx_done      (rx_done),
        .rx_ok        (rx_ok),
        .rx_err       (rx_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output log, written only by this process.
    int         valid_cnt = 0;
    int         pid_cnt   = 0;
    int         done_cnt  = 0;
    logic [7:0] data_log[$];
    logic [3:0] last_pid  = '0;
    logic       last_ok   = 1'b0;
    logic [2:0] last_err  = '0;
    logic [6:0] last_len  = '0;

    always @(negedge c_48) begin
        if (rx_valid) begin
            valid_cnt++;
            data_log.push_back(rx_data);
        end
        if (rx_pid_valid) begin
            pid_cnt++;
            last_pid = rx_pid;
        end
        if (rx_done) begin
            done_cnt++;
            last_ok  = rx_ok;
            last_err = rx_err;
            last_len = rx_len;
        end
    end

    int v0, p0, dn0;

    task automatic tick(input int n);
        repeat (n) @(negedge c_48);
    endtask

    task automatic send_bit(input logic b);
        d  = b;
        dv = 1'b1;
        tick(1);
        dv = 1'b0;
        d  = 1'b0;
        tick(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_eop();
        eop = 1'b1;
        tick(3);
        eop = 1'b0;
        tick(4);
    endtask

    task automatic mark();
        v0  = valid_cnt;
        p0  = pid_cnt;
        dn0 = done_cnt;
    endtask

    task automatic send_pkt(input byte_q_t bytes);
        mark();
        send_sync();
        foreach (bytes[i]) send_byte(bytes[i]);
        send_eop();
    endtask

    task automatic ack_test(input string tag);
        send_pkt('{8'hD2});
        check({tag, "_pid_pulses"}, 32'(pid_cnt - p0), 32'd1);
        check({tag, "_pid"}, 32'(last_pid), 32'h2);
        check({tag, "_done"}, 32'(done_cnt - dn0), 32'd1);
        check({tag, "_len"}, 32'(last_len), 32'd0);
        check({tag, "_ok"}, 32'(last_ok), 32'd1);
    endtask

    byte_q_t pkt;

    initial begin
        tick(3);
        check("reset_outputs",
              32'({rx_pid, rx_pid_valid, rx_data, rx_valid, rx_len, rx_done, rx_ok, rx_err}),
              32'd0);
        rst = 1'b0;
        tick(4);

        // SETUP token, addr 0 endp 0
        send_pkt('{8'h2D, 8'h00, 8'h10});
        check("setup_pid_pulses", 32'(pid_cnt - p0), 32'd1);
        check("setup_pid", 32'(last_pid), 32'hD);
        check("setup_valids", 32'(valid_cnt - v0), 32'd2);
        check("setup_byte0", 32'(data_log[v0]), 32'h00);
        check("setup_byte1", 32'(data_log[v0 + 1]), 32'h10);
        check("setup_len", 32'(last_len), 32'd2);
        check("setup_done_ok", 32'({last_ok, last_err}), 32'b1_000);

        // DATA0 GET_DESCRIPTOR with CRC16
        send_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94});
        check("data0_valids", 32'(valid_cnt - v0), 32'd10);
        check("data0_first", 32'(data_log[v0]), 32'h80);
        check("data0_last", 32'(data_log[v0 + 9]), 32'h94);
        check("data0_len", 32'(last_len), 32'd10);
        check("data0_ok", 32'({last_ok, last_err}), 32'b1_000);

        // Same packet with one payload bit flipped
        send_pkt('{8'hC3, 8'h80, 8'h07, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94});
        check("flip_valids", 32'(valid_cnt - v0), 32'd10);
        check("flip_err", 32'(last_err), 32'({2'b00, CRC_ON}));
        check("flip_ok", 32'(last_ok), 32'(!CRC_ON));

        ack_test("ack");

        // Corrupt PID byte, trailing byte must be dropped
        send_pkt('{8'hD3, 8'h55});
        check("badpid_pid_pulses", 32'(pid_cnt - p0), 32'd0);
        check("badpid_valids", 32'(valid_cnt - v0), 32'd0);
        check("badpid_done", 32'(done_cnt - dn0), 32'd1);
        check("badpid_err0_ok", 32'({last_err[0], last_ok}), 32'b10);

        // DATA1 empty plus 3 stray bits
        mark();
        send_sync();
        send_byte(8'h4B);
        send_byte(8'h00);
        send_byte(8'h00);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_eop();
        check("align_err", 32'(last_err[1]), 32'd1);
        check("align_len", 32'(last_len), 32'd2);
        check("align_ok", 32'(last_ok), 32'd0);

        // 70 bytes after a DATA0 PID
        pkt = '{8'hC3};
        for (int i = 0; i < 70; i++) pkt.push_back(8'(i * 7 + 1));
        send_pkt(pkt);
        check("ovf_valids", 32'(valid_cnt - v0), 32'd66);
        check("ovf_last_byte", 32'(data_log[v0 + 65]), 32'hC8);
        check("ovf_flag", 32'(last_err[2]), 32'd1);
        check("ovf_ok", 32'(last_ok), 32'd0);
        check("ovf_len", 32'(last_len), 32'd66);

        // Only two zeros before the 1: no packet should be seen
        mark();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_byte(8'hD2);
        send_eop();
        check("shortsync_pid", 32'(pid_cnt - p0), 32'd0);
        check("shortsync_valid", 32'(valid_cnt - v0), 32'd0);
        check("shortsync_done", 32'(done_cnt - dn0), 32'd0);

        // Reset in the middle of a DATA0 packet
        mark();
        send_sync();
        send_byte(8'hC3);
        send_byte(8'h80);
        send_byte(8'h06);
        check("midrst_pre_len", 32'(rx_len), 32'd2);
        rst = 1'b1;
        tick(1);
        check("midrst_outputs",
              32'({rx_pid, rx_pid_valid, rx_data, rx_valid, rx_len, rx_done, rx_ok, rx_err}),
              32'd0);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("midrst_no_done", 32'(done_cnt - dn0), 32'd0);

        ack_test("ack_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Backstop against a stalled run.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
